// File: rtl/fb_write_scheduler_pkg.sv
// Shared definitions for the frame-buffer write scheduler.
// The state records which requester won arbitration on the previous cycle.
package fb_write_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XL   = 2'd1,
        ST_CPU  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO that buffers CPU frame-buffer writes ahead of arbitration.
// Pointers wrap naturally because DEPTH is a power of two.
module fb_wr_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (PW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage needs no reset; count and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Arbitrates buffered CPU writes against unbuffered line-engine (XL) writes
// into a single registered frame-buffer write port, bounding CPU starvation.
module fb_write_scheduler
    import fb_write_scheduler_pkg::*;
#(
    parameter int unsigned MEM_WIDTH      = 1,
    parameter int unsigned MEM_DEPTH      = 786432,
    parameter int unsigned MEM_ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int unsigned CPU_FIFO_DEPTH = 4,
    parameter int unsigned STARVE_LIMIT   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cpu_wr_valid,
    output logic                            cpu_wr_ready,
    input  logic [MEM_ADDR_WIDTH-1:0]       cpu_wr_addr,
    input  logic [MEM_WIDTH-1:0]            cpu_wr_data,
    input  logic                            xl_wr_valid,
    output logic                            xl_wr_ready,
    input  logic [MEM_ADDR_WIDTH-1:0]       xl_wr_addr,
    input  logic [MEM_WIDTH-1:0]            xl_wr_data,
    output logic                            frame_wr_en,
    output logic [MEM_ADDR_WIDTH-1:0]       frame_wr_addr,
    output logic [MEM_WIDTH-1:0]            frame_wr_data,
    output logic [$clog2(CPU_FIFO_DEPTH):0] cpu_fifo_count
);
    localparam int unsigned FW = MEM_ADDR_WIDTH + MEM_WIDTH;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [SW-1:0] streak;
    logic [SW-1:0] streak_nxt;
    logic [FW-1:0] fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          xl_grant;
    logic          cpu_grant;

    assign cpu_wr_ready = !fifo_full && !rst;
    assign xl_wr_ready  = xl_grant;

    fb_wr_fifo #(
        .WIDTH (FW),
        .DEPTH (CPU_FIFO_DEPTH)
    ) u_cpu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cpu_wr_valid && cpu_wr_ready),
        .push_data ({cpu_wr_addr, cpu_wr_data}),
        .pop       (cpu_grant),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (cpu_fifo_count)
    );

    always_comb begin
        xl_grant   = 1'b0;
        cpu_grant  = 1'b0;
        state_nxt  = ST_IDLE;
        streak_nxt = streak;
        if (!rst) begin
            if (xl_wr_valid && (fifo_empty || streak < STREAK_MAX)) begin
                xl_grant  = 1'b1;
                state_nxt = ST_XL;
            end else if (!fifo_empty) begin
                cpu_grant = 1'b1;
                state_nxt = ST_CPU;
            end
        end
        if (cpu_grant || fifo_empty) begin
            streak_nxt = '0;
        end else if (xl_grant && streak < STREAK_MAX) begin
            streak_nxt = streak + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            streak        <= '0;
            frame_wr_addr <= '0;
            frame_wr_data <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
            if (xl_grant) begin
                frame_wr_addr <= xl_wr_addr;
                frame_wr_data <= xl_wr_data;
            end else if (cpu_grant) begin
                {frame_wr_addr, frame_wr_data} <= fifo_head;
            end
        end
    end

    // The last-grant register doubles as the registered write enable.
    assign frame_wr_en = (state != ST_IDLE);

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler: directed vector table, corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_fb_write_scheduler;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cpu_wr_valid;
    logic           cpu_wr_ready;
    logic [AW-1:0]  cpu_wr_addr;
    logic [DW-1:0]  cpu_wr_data;
    logic           xl_wr_valid;
    logic           xl_wr_ready;
    logic [AW-1:0]  xl_wr_addr;
    logic [DW-1:0]  xl_wr_data;
    logic           frame_wr_en;
    logic [AW-1:0]  frame_wr_addr;
    logic [DW-1:0]  frame_wr_data;
    logic [2:0]     cpu_fifo_count;

    fb_write_scheduler #(
        .MEM_WIDTH      (DW),
        .MEM_DEPTH      (256),
        .MEM_ADDR_WIDTH (AW),
        .CPU_FIFO_DEPTH (DEPTH),
        .STARVE_LIMIT   (LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_wr_valid   (cpu_wr_valid),
        .cpu_wr_ready   (cpu_wr_ready),
        .cpu_wr_addr    (cpu_wr_addr),
        .cpu_wr_data    (cpu_wr_data),
        .xl_wr_valid    (xl_wr_valid),
        .xl_wr_ready    (xl_wr_ready),
        .xl_wr_addr     (xl_wr_addr),
        .xl_wr_data     (xl_wr_data),
        .frame_wr_en    (frame_wr_en),
        .frame_wr_addr  (frame_wr_addr),
        .frame_wr_data  (frame_wr_data),
        .cpu_fifo_count (cpu_fifo_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of buffered {addr,data} words plus the
    // starvation streak and the pending registered write.
    int unsigned mq[$];
    int unsigned m_streak;
    bit          m_en;
    int unsigned m_addr;
    int unsigned m_data;
    bit          m_xl_g;
    int unsigned seen[$];

    typedef struct {
        bit          cv;
        logic [7:0]  ca;
        logic [7:0]  cd;
        bit          xv;
        logic [7:0]  xa;
        logic [7:0]  xd;
        bit          e_crdy;
        bit          e_xrdy;
        bit          e_en;
        logic [7:0]  e_addr;
        logic [7:0]  e_data;
        int unsigned e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit cv, logic [7:0] ca, logic [7:0] cd,
                                bit xv, logic [7:0] xa, logic [7:0] xd,
                                bit ecr, bit exr, bit een,
                                logic [7:0] ea, logic [7:0] ed, int unsigned ec);
        vec_t v;
        v.cv = cv; v.ca = ca; v.cd = cd;
        v.xv = xv; v.xa = xa; v.xd = xd;
        v.e_crdy = ecr; v.e_xrdy = exr; v.e_en = een;
        v.e_addr = ea; v.e_data = ed; v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit cv, input logic [7:0] ca, input logic [7:0] cd,
                         input bit xv, input logic [7:0] xa, input logic [7:0] xd);
        cpu_wr_valid = cv;
        cpu_wr_addr  = ca;
        cpu_wr_data  = cd;
        xl_wr_valid  = xv;
        xl_wr_addr   = xa;
        xl_wr_data   = xd;
    endtask

    task automatic model_clear();
        mq.delete();
        m_streak = 0;
        m_en     = 1'b0;
        m_addr   = 0;
        m_data   = 0;
        m_xl_g   = 1'b0;
    endtask

    // Called mid-cycle with inputs settled: compare, then advance the model
    // across the next rising edge and return at posedge+1.
    task automatic step_body();
        bit          xl_g;
        bit          cpu_g;
        bit          push;
        int unsigned n_streak;
        int unsigned in_word;
        int unsigned xa;
        int unsigned xd;
        xl_g  = xl_wr_valid && (mq.size() == 0 || m_streak < LIMIT);
        cpu_g = !xl_g && mq.size() != 0;
        push  = cpu_wr_valid && mq.size() < DEPTH;
        check("model_cpu_ready", cpu_wr_ready, mq.size() < DEPTH);
        check("model_xl_ready", xl_wr_ready, xl_g);
        check("model_count", cpu_fifo_count, mq.size());
        check("model_en", frame_wr_en, m_en);
        if (m_en) begin
            check("model_addr", frame_wr_addr, m_addr);
            check("model_data", frame_wr_data, m_data);
        end
        if (frame_wr_en) seen.push_back(frame_wr_addr);
        in_word = {cpu_wr_addr, cpu_wr_data};
        xa = xl_wr_addr;
        xd = xl_wr_data;
        if (cpu_g || mq.size() == 0) n_streak = 0;
        else if (xl_g && m_streak < LIMIT) n_streak = m_streak + 1;
        else n_streak = m_streak;
        @(posedge clk);
        m_en = xl_g || cpu_g;
        if (xl_g) begin
            m_addr = xa;
            m_data = xd;
        end else if (cpu_g) begin
            m_addr = mq[0] >> 8;
            m_data = mq[0] & 32'hFF;
        end
        if (cpu_g) void'(mq.pop_front());
        if (push) mq.push_back(in_word);
        m_streak = n_streak;
        m_xl_g   = xl_g;
        #1;
    endtask

    task automatic cycle();
        #3;
        step_body();
    endtask

    // Asserts reset between edges, checks the immediate effect, then
    // releases it just after a rising edge.
    task automatic reset_and_check(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_rst_en"}, frame_wr_en, 0);
        check({tag, "_rst_addr"}, frame_wr_addr, 0);
        check({tag, "_rst_data"}, frame_wr_data, 0);
        check({tag, "_rst_count"}, cpu_fifo_count, 0);
        check({tag, "_rst_cpu_ready"}, cpu_wr_ready, 0);
        check({tag, "_rst_xl_ready"}, xl_wr_ready, 0);
        model_clear();
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_cpu_order(input string name, input int unsigned first, input int unsigned n);
        int unsigned cpu_seen[$];
        foreach (seen[i]) if (seen[i] < 32'h80) cpu_seen.push_back(seen[i]);
        check({name, "_n"}, cpu_seen.size(), n);
        for (int i = 0; i < cpu_seen.size() && i < n; i++)
            check($sformatf("%s_%0d", name, i), cpu_seen[i], first + i);
    endtask

    initial begin
        logic [7:0]  xa;
        int unsigned cp[3];
        int unsigned xp[3];
        cp = '{30, 70, 90};
        xp = '{30, 90, 50};

        // Idle-block sequences, starting from reset with streak 0.
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 8'h10, 8'h01, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 1, 8'h10, 8'h01, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 8'h20, 8'h5A, 1, 1, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 1, 8'h20, 8'h5A, 0));
        tbl.push_back(mk(1, 8'h30, 8'h33, 1, 8'h40, 8'hA0, 1, 1, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 8'h41, 8'hA1, 1, 1, 1, 8'h40, 8'hA0, 1));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 8'h42, 8'hA2, 1, 1, 1, 8'h41, 8'hA1, 1));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 8'h43, 8'hA3, 1, 1, 1, 8'h42, 8'hA2, 1));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 8'h44, 8'hA4, 1, 1, 1, 8'h43, 8'hA3, 1));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 8'h45, 8'hA5, 1, 0, 1, 8'h44, 8'hA4, 1));
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 8'h45, 8'hA5, 1, 1, 1, 8'h30, 8'h33, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 1, 8'h45, 8'hA5, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0));

        drive(1, 8'h01, 8'h01, 1, 8'h02, 8'h02);
        #2;
        reset_and_check("init");

        foreach (tbl[k]) begin
            drive(tbl[k].cv, tbl[k].ca, tbl[k].cd, tbl[k].xv, tbl[k].xa, tbl[k].xd);
            #3;
            check($sformatf("vec%0d_cpu_ready", k), cpu_wr_ready, tbl[k].e_crdy);
            check($sformatf("vec%0d_xl_ready", k), xl_wr_ready, tbl[k].e_xrdy);
            check($sformatf("vec%0d_en", k), frame_wr_en, tbl[k].e_en);
            check($sformatf("vec%0d_count", k), cpu_fifo_count, tbl[k].e_cnt);
            if (tbl[k].e_en) begin
                check($sformatf("vec%0d_addr", k), frame_wr_addr, tbl[k].e_addr);
                check($sformatf("vec%0d_data", k), frame_wr_data, tbl[k].e_data);
            end
            step_body();
        end

        // Full FIFO while XL saturates: fifth push is refused.
        reset_and_check("full");
        seen.delete();
        xa = 8'h80;
        for (int i = 0; i < 5; i++) begin
            drive(1, i[7:0], 8'hC0 + i[7:0], 1, xa, xa ^ 8'hFF);
            #3;
            if (i == 4) begin
                check("full_cpu_ready", cpu_wr_ready, 0);
                check("full_count", cpu_fifo_count, 4);
            end
            step_body();
            if (m_xl_g) xa = xa + 8'd1;
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (8) cycle();
        check_cpu_order("full_order", 0, 4);

        // Steady push+pop at count 2 across several pointer wraps.
        reset_and_check("pp");
        seen.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'h10 + i[7:0], 8'h20 + i[7:0], i < 2, 8'h90 + i[7:0], 8'h55);
            #3;
            if (i >= 2) check($sformatf("pp_count_%0d", i), cpu_fifo_count, 2);
            step_body();
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (5) cycle();
        check_cpu_order("pp_order", 32'h10, 8);

        // Reset while three CPU writes are buffered and a write is issuing.
        reset_and_check("mid0");
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h50 + i[7:0], 8'h11, 1, 8'hA0 + i[7:0], 8'h22);
            cycle();
        end
        check("mid_pre_count", cpu_fifo_count, 3);
        check("mid_pre_en", frame_wr_en, 1);
        reset_and_check("mid");
        seen.delete();
        repeat (6) cycle();
        check("mid_no_write", seen.size(), 0);

        // Randomized traffic; XL holds its request until granted.
        for (int seg = 0; seg < 3; seg++) begin
            for (int n = 0; n < 700; n++) begin
                if (!(xl_wr_valid && !m_xl_g)) begin
                    xl_wr_valid = ($urandom_range(99) < xp[seg]);
                    xl_wr_addr  = 8'($urandom);
                    xl_wr_data  = 8'($urandom);
                end
                cpu_wr_valid = ($urandom_range(99) < cp[seg]);
                cpu_wr_addr  = 8'($urandom);
                cpu_wr_data  = 8'($urandom);
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_write_scheduler.md
FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 1, frame-buffer pixel data width.
REQ-002 SHALL have parameter MEM_DEPTH, default 786432, frame-buffer entries.
REQ-003 SHALL have parameter MEM_ADDR_WIDTH, default `log2(MEM_DEPTH), address width.
REQ-004 SHALL have parameter CPU_FIFO_DEPTH, default 4 (power of 2, >=2), CPU write buffer entries.
REQ-005 SHALL have parameter STARVE_LIMIT, default 8 (>=1), max consecutive XL grants while CPU writes wait.
REQ-006 SHALL have ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- cpu_wr_valid  input  1  CPU write request
- cpu_wr_ready  output  1  CPU write accepted when high with valid
- cpu_wr_addr  input  MEM_ADDR_WIDTH  CPU write address
- cpu_wr_data  input  MEM_WIDTH  CPU write data
- xl_wr_valid  input  1  XL (line engine) write request
- xl_wr_ready  output  1  XL write granted this cycle
- xl_wr_addr  input  MEM_ADDR_WIDTH  XL write address
- xl_wr_data  input  MEM_WIDTH  XL write data
- frame_wr_en  output  1  registered frame-buffer write enable
- frame_wr_addr  output  MEM_ADDR_WIDTH  registered write address
- frame_wr_data  output  MEM_WIDTH  registered write data
- cpu_fifo_count  output  `log2(CPU_FIFO_DEPTH)+1  buffered CPU writes

Function
REQ-007 SHALL accept a CPU write on a cycle with cpu_wr_valid && cpu_wr_ready, pushing {addr,data} into the CPU FIFO.
REQ-008 SHALL drive cpu_wr_ready = !fifo_full, independent of same-cycle pop (no push when full, even if popping).
REQ-009 SHALL issue at most one write per cycle; XL is unbuffered and SHALL hold its request until xl_wr_ready.
REQ-010 SHALL grant XL (xl_wr_ready=1, combinational) when xl_wr_valid && (fifo_empty || streak < STARVE_LIMIT).
REQ-011 SHALL otherwise pop the FIFO head when fifo non-empty (CPU grant); else no grant.
REQ-012 SHALL keep a streak counter: +1 on XL grant with FIFO non-empty, saturating at STARVE_LIMIT; cleared on CPU grant or when FIFO is empty.
REQ-013 SHALL hold a last-grant state register with states IDLE, XL, CPU: next state = XL on XL grant, CPU on CPU grant, IDLE on no grant.
REQ-014 SHALL register the granted write: frame_wr_en/addr/data valid exactly 1 cycle after grant; frame_wr_en=0 on the cycle after IDLE.
REQ-015 SHALL preserve CPU write order (FIFO); CPU writes pushed while FIFO is empty SHALL NOT bypass the FIFO (min CPU latency 2 cycles accept->frame_wr_en).
REQ-016 SHALL wrap FIFO read/write pointers modulo CPU_FIFO_DEPTH; simultaneous push and pop SHALL leave count unchanged.
REQ-017 cpu_fifo_count SHALL equal pushes minus pops since reset, range 0..CPU_FIFO_DEPTH.
REQ-018 SHALL not alter addr/data values; no address range checking.

Reset
REQ-019 On rst high (asynchronous), SHALL clear FIFO pointers and count to 0, streak to 0, state to IDLE, frame_wr_en/addr/data to 0.
REQ-020 During rst, cpu_wr_ready and xl_wr_ready SHALL be 0; writes in flight or buffered at reset SHALL be discarded.
REQ-021 First grant SHALL occur no earlier than the first rising clk after rst deasserts.

Structure
REQ-022 State encodings (IDLE=2'd0, XL=2'd1, CPU=2'd2) SHALL live in shared header fb_arb.vh alongside util.vh.
REQ-023 CPU buffer SHALL be a separate sub-module fb_wr_fifo (synchronous FIFO, parameterised width/depth, full/empty/count).
REQ-024 Arbitration, streak counter, state register and output register SHALL reside in fb_write_scheduler.

Verification
REQ-025 CPU only: push addr 0x10 data 1 on idle block -> frame_wr_en high 2 cycles later, addr 0x10, data 1; count 1 then 0.
REQ-026 XL only: xl_wr_valid addr 0x20 -> xl_wr_ready same cycle, frame_wr_en/addr 0x20 next cycle.
REQ-027 Starvation (STARVE_LIMIT=4): XL valid continuously, one CPU write buffered -> 4 XL grants, then 1 CPU grant, then XL resumes; streak back to 0.
REQ-028 Full (depth 4): 5 back-to-back CPU pushes while XL saturates -> cpu_wr_ready low on 5th, count 4; drained in order 0,1,2,3.
REQ-029 Simultaneous push/pop at count 2 with XL idle -> count stays 2, output order preserved, pointer wrap after 4+ writes.
REQ-030 Reset mid-operation: assert rst with count 3 and frame_wr_en high -> all outputs 0 immediately, count 0, no buffered write emitted after release.
